// File: rtl/line_fetch_scheduler.sv
// Frame sequencer for the 3x3 line buffer: fetches rows, strobes shifts, launches the kernel per row.
// Optional fetch watchdog enabled by defining LFS_WATCHDOG_EN (adds parameter WD_CYCLES and a sticky wd_err).
module line_fetch_scheduler #(
  parameter int ROWS  = 720,
  parameter int ROW_W = 10
`ifdef LFS_WATCHDOG_EN
  , parameter int WD_CYCLES = 1023
`endif
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             frame_start,
  output logic             busy,
  output logic             frame_done,
  output logic             mem_req,
  output logic [ROW_W-1:0] mem_addr,
  input  logic             mem_ack,
  output logic             lb_shift,
  output logic             lb_zero,
  output logic [ROW_W-1:0] calc_row,
  output logic             row_start,
  input  logic             row_done,
  output logic             wd_err
);

  typedef enum logic [2:0] {IDLE, ZTOP, FETCH, SHIFT, ZBOT, RUN, DONE} state_t;

  localparam logic [ROW_W-1:0] ROWS_W   = ROW_W'(ROWS);
  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(ROWS - 1);

  state_t           state_reg, state_next;
  logic [ROW_W-1:0] f_reg, f_next;
  logic [ROW_W-1:0] calc_row_reg, calc_row_next;
  logic [ROW_W-1:0] mem_addr_reg;
  logic             busy_reg, frame_done_reg, mem_req_reg;
  logic             lb_shift_reg, lb_zero_reg, row_start_reg;
  logic             wd_trip;

`ifdef LFS_WATCHDOG_EN
  localparam int WD_W = $clog2(WD_CYCLES + 1);

  logic [WD_W-1:0] wd_cnt_reg;
  logic            wd_err_reg;

  // Counter holds the number of FETCH cycles already spent without an ack.
  assign wd_trip = (state_reg == FETCH) && !mem_ack &&
                   (wd_cnt_reg == WD_W'(WD_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      wd_cnt_reg <= '0;
      wd_err_reg <= 1'b0;
    end else begin
      if (state_reg == FETCH && state_next == FETCH)
        wd_cnt_reg <= wd_cnt_reg + 1'b1;
      else
        wd_cnt_reg <= '0;
      if (wd_trip)
        wd_err_reg <= 1'b1;
    end
  end

  assign wd_err = wd_err_reg;
`else
  assign wd_trip = 1'b0;
  assign wd_err  = 1'b0;
`endif

  always_comb begin
    state_next    = state_reg;
    f_next        = f_reg;
    calc_row_next = calc_row_reg;
    case (state_reg)
      IDLE: begin
        if (frame_start) begin
          state_next    = ZTOP;
          f_next        = '0;
          calc_row_next = '0;
        end
      end
      ZTOP:  state_next = FETCH;
      FETCH: begin
        if (wd_trip)
          state_next = IDLE;
        else if (mem_ack)
          state_next = SHIFT;
      end
      SHIFT: begin
        if (f_reg != ROWS_W)
          f_next = f_reg + 1'b1;
        // The first fetched row only primes the window; a second fetch follows.
        state_next = (f_reg == '0) ? FETCH : RUN;
      end
      ZBOT:  state_next = RUN;
      RUN: begin
        // row_done in the entry cycle belongs to the previous row and is ignored.
        if (row_done && !row_start_reg) begin
          if (calc_row_reg == LAST_ROW) begin
            state_next = DONE;
          end else begin
            calc_row_next = calc_row_reg + 1'b1;
            state_next    = (f_reg < ROWS_W) ? FETCH : ZBOT;
          end
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Outputs are registered decodes of the next state so they line up with the state they describe.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= IDLE;
      f_reg          <= '0;
      calc_row_reg   <= '0;
      mem_addr_reg   <= '0;
      busy_reg       <= 1'b0;
      frame_done_reg <= 1'b0;
      mem_req_reg    <= 1'b0;
      lb_shift_reg   <= 1'b0;
      lb_zero_reg    <= 1'b0;
      row_start_reg  <= 1'b0;
    end else begin
      state_reg      <= state_next;
      f_reg          <= f_next;
      calc_row_reg   <= calc_row_next;
      busy_reg       <= (state_next != IDLE) && (state_next != DONE);
      frame_done_reg <= (state_next == DONE);
      mem_req_reg    <= (state_next == FETCH);
      if (state_next == FETCH)
        mem_addr_reg <= f_next;
      lb_shift_reg   <= (state_next inside {ZTOP, SHIFT, ZBOT});
      lb_zero_reg    <= (state_next == ZTOP) || (state_next == ZBOT);
      row_start_reg  <= (state_next == RUN) && (state_reg != RUN);
    end
  end

  assign busy       = busy_reg;
  assign frame_done = frame_done_reg;
  assign mem_req    = mem_req_reg;
  assign mem_addr   = mem_addr_reg;
  assign lb_shift   = lb_shift_reg;
  assign lb_zero    = lb_zero_reg;
  assign calc_row   = calc_row_reg;
  assign row_start  = row_start_reg;

endmodule

// File: tb/tb_line_fetch_scheduler.sv
// Scoreboard bench for line_fetch_scheduler: expected output events are queued per frame and matched in order.
module tb_line_fetch_scheduler;

  localparam int ROWS  = 4;
  localparam int ROW_W = 10;
  localparam logic [7:0] K_FETCH = 8'd1;
  localparam logic [7:0] K_SHIFT = 8'd2;
  localparam logic [7:0] K_START = 8'd3;
  localparam logic [7:0] K_DONE  = 8'd4;

  logic             clk = 1'b0;
  logic             rst, frame_start, mem_ack, row_done;
  logic             busy, frame_done, mem_req, lb_shift, lb_zero, row_start, wd_err;
  logic [ROW_W-1:0] mem_addr, calc_row;

  logic [31:0] q[$];
  int checks = 0;
  int errors = 0;
  int slow_addr = -1;
  int slow_len  = 1;
  int spur_req  = 0;

  line_fetch_scheduler #(
    .ROWS(ROWS),
    .ROW_W(ROW_W)
`ifdef LFS_WATCHDOG_EN
    , .WD_CYCLES(8)
`endif
  ) dut (
    .clk(clk), .rst(rst), .frame_start(frame_start), .busy(busy),
    .frame_done(frame_done), .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_ack(mem_ack), .lb_shift(lb_shift), .lb_zero(lb_zero),
    .calc_row(calc_row), .row_start(row_start), .row_done(row_done),
    .wd_err(wd_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end else begin
      $display("ok   %s %h", tag, got);
    end
  endtask

  function automatic logic [31:0] ev(input logic [7:0] k, input int len, input int val);
    return {k, 12'(len), 12'(val)};
  endfunction

  function automatic int ack_len(input int a);
    return (a == slow_addr) ? slow_len : 1;
  endfunction

  task automatic emit(input logic [31:0] e);
    if (q.size() == 0)
      chk("unexpected_event", e, 32'h0);
    else
      chk("event", e, q.pop_front());
  endtask

  task automatic push_frame();
    q.push_back(ev(K_SHIFT, 0, 1));
    q.push_back(ev(K_FETCH, ack_len(0), 0));
    q.push_back(ev(K_SHIFT, 0, 0));
    for (int r = 0; r < ROWS; r++) begin
      if (r + 1 < ROWS) begin
        q.push_back(ev(K_FETCH, ack_len(r + 1), r + 1));
        q.push_back(ev(K_SHIFT, 0, 0));
      end else begin
        q.push_back(ev(K_SHIFT, 0, 1));
      end
      q.push_back(ev(K_START, 0, r));
    end
    q.push_back(ev(K_DONE, 0, 0));
  endtask

  // Monitor: turns output activity into events (fetch = addr + cycles held, reported when mem_req drops).
  initial begin
    logic             req_prev;
    logic [ROW_W-1:0] req_addr;
    int               req_cnt;
    bit               addr_bad;
    req_prev = 1'b0; req_addr = '0; req_cnt = 0; addr_bad = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        req_prev = 1'b0;
        req_cnt  = 0;
      end else begin
        if (mem_req) begin
          if (!req_prev) begin
            req_addr = mem_addr;
            addr_bad = 1'b0;
            req_cnt  = 0;
          end else if (mem_addr != req_addr) begin
            addr_bad = 1'b1;
          end
          req_cnt++;
        end else if (req_prev) begin
          emit(ev(K_FETCH, req_cnt, addr_bad ? 32'hfff : int'(req_addr)));
        end
        req_prev = mem_req;
        if (lb_shift)   emit(ev(K_SHIFT, 0, int'(lb_zero)));
        if (row_start)  emit(ev(K_START, 0, int'(calc_row)));
        if (frame_done) emit(ev(K_DONE, 0, int'(busy)));
      end
    end
  end

  // Frame memory: acks after ack_len(addr) cycles of mem_req.
  initial begin
    int rcnt;
    rcnt = 0;
    mem_ack = 1'b0;
    forever begin
      @(negedge clk);
      mem_ack = 1'b0;
      if (rst || !mem_req) begin
        rcnt = 0;
      end else begin
        rcnt++;
        if (rcnt == ack_len(int'(mem_addr)))
          mem_ack = 1'b1;
      end
    end
  end

  // Kernel engine: row_done 3 cycles after row_start, plus an optional stray pulse during fetch of row 2.
  initial begin
    int cd;
    int spur_ack;
    cd = 0; spur_ack = 0;
    row_done = 1'b0;
    forever begin
      @(negedge clk);
      row_done = 1'b0;
      if (rst) begin
        cd = 0;
      end else begin
        if (cd > 0) begin
          cd--;
          if (cd == 0) row_done = 1'b1;
        end
        if (row_start) cd = 3;
        if (spur_req != spur_ack && mem_req && mem_addr == 10'd2 && cd == 0) begin
          row_done = 1'b1;
          spur_ack = spur_req;
        end
      end
    end
  end

  task automatic start_pulse();
    @(negedge clk);
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
    chk("busy_rise", {31'b0, busy}, 32'd1);
    @(negedge clk);
    chk("first_req", {21'b0, mem_req, mem_addr}, {21'b0, 1'b1, 10'd0});
  endtask

  task automatic drain(input bit fs_in_run, input bit fs_on_done);
    int  budget;
    bit  injected;
    budget = 0;
    injected = 1'b0;
    while (q.size() != 0 && budget < 500) begin
      @(negedge clk);
      budget++;
      frame_start = 1'b0;
      if (fs_in_run && !injected && row_start && calc_row == 10'd1) begin
        frame_start = 1'b1;
        injected = 1'b1;
      end
      if (fs_on_done && frame_done)
        frame_start = 1'b1;
    end
    if (budget >= 500)
      chk("drain_timeout", q.size(), 32'd0);
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      frame_start = 1'b0;
    end
    chk("idle_after_frame", {30'b0, busy, mem_req}, 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    frame_start = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_outputs", {5'b0, busy, frame_done, mem_req, lb_shift, lb_zero,
                          row_start, wd_err, mem_addr, calc_row}, 32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Nominal frame
    push_frame();
    start_pulse();
    drain(1'b0, 1'b0);

    // Slow ack on row 2
    slow_addr = 2;
    slow_len  = 6;
    push_frame();
    start_pulse();
    drain(1'b0, 1'b0);
    slow_addr = -1;
    slow_len  = 1;

    // frame_start during RUN and in DONE, stray row_done in FETCH
    spur_req++;
    push_frame();
    start_pulse();
    drain(1'b1, 1'b1);

    // Reset in the middle of fetching row 2
    begin
      int  budget;
      push_frame();
      start_pulse();
      budget = 0;
      while (!(mem_req && mem_addr == 10'd2) && budget < 200) begin
        @(negedge clk);
        budget++;
      end
      if (budget >= 200) chk("reach_row2_timeout", budget, 32'd0);
      rst = 1'b1;
      @(negedge clk);
      chk("midframe_reset", {5'b0, busy, frame_done, mem_req, lb_shift, lb_zero,
                             row_start, wd_err, mem_addr, calc_row}, 32'd0);
      q.delete();
      @(negedge clk);
      rst = 1'b0;
      repeat (3) @(negedge clk);
    end
    push_frame();
    start_pulse();
    drain(1'b0, 1'b0);

`ifdef LFS_WATCHDOG_EN
    // Withheld ack on row 1 trips the watchdog after 8 FETCH cycles
    slow_addr = 1;
    slow_len  = 1000;
    q.push_back(ev(K_SHIFT, 0, 1));
    q.push_back(ev(K_FETCH, 1, 0));
    q.push_back(ev(K_SHIFT, 0, 0));
    q.push_back(ev(K_FETCH, 8, 1));
    start_pulse();
    drain(1'b0, 1'b0);
    chk("wd_err_set", {29'b0, wd_err, busy, mem_req}, {29'b0, 3'b100});
    slow_addr = -1;
    slow_len  = 1;
    push_frame();
    start_pulse();
    drain(1'b0, 1'b0);
    chk("wd_err_sticky", {31'b0, wd_err}, 32'd1);
`else
    chk("wd_err_tied", {31'b0, wd_err}, 32'd0);
`endif

    chk("queue_empty", q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got %0t expected finish", $time);
    $fatal(1, "bench timeout");
  end

endmodule
